// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package prog_loader_pkg;

  localparam int          WORD_BYTES    = 4;
  localparam logic [7:0]  ACK_BYTE_DFLT = 8'hAA;
  localparam logic [7:0]  NAK_BYTE_DFLT = 8'h55;

  typedef enum logic [2:0] {
    ST_LEN  = 3'd0,
    ST_DATA = 3'd1,
    ST_CHK  = 3'd2,
    ST_ACK  = 3'd3,
    ST_NAK  = 3'd4,
    ST_FIN  = 3'd5,
    ST_HALT = 3'd6
  } state_t;

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Assembles little-endian 32-bit words from a byte stream (first byte = LSB).
// Latency: combinational; word/word_valid are valid in the cycle the 4th byte arrives.
// Backpressure: none; every rx_valid byte is taken unless clear is high.
// Ports: clk, rstn, rx_valid/rx_data (byte in), clear (drop partial word and
//        ignore input), word (assembled word), word_valid (1-cycle pulse).
module prog_loader_byte_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid
);

  // Holds the three bytes already received, newest in the top byte.
  logic [23:0] shift_q;
  logic [1:0]  cnt_q;
  logic        take;

  assign take       = rx_valid && !clear;
  assign word       = {rx_data, shift_q};
  assign word_valid = take && (cnt_q == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      cnt_q   <= '0;
    end else if (take) begin
      shift_q <= {rx_data, shift_q[23:8]};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: reads word count + words from UART bytes, writes them to
// instruction memory, then hands memory to the core and sends ACK/NAK.
// Latency: memory write issued 1 cycle after the byte completing a word.
// Backpressure: none on rx (bytes never dropped while loading); tx byte is
//               held until tx_ready.
// Ports: clk, rstn; rx_valid/rx_data in; tx_valid/tx_data/tx_ready out;
//        io_sel/we/en/addr_io/din memory port; done, err status.
// Optional: define PROG_LOADER_CHECKSUM_EN to require a trailing 32-bit
//           wrapping sum of all data words before ACK.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 32768,
  parameter logic [7:0]  ACK_BYTE  = ACK_BYTE_DFLT,
  parameter logic [7:0]  NAK_BYTE  = NAK_BYTE_DFLT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        io_sel,
  output logic        we,
  output logic        en,
  output logic [31:0] addr_io,
  output logic [31:0] din,
  output logic        done,
  output logic        err
);

  localparam int IDX_W = $clog2(MAX_WORDS);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CHK;
`else
  localparam state_t ST_AFTER_DATA = ST_ACK;
`endif

  state_t             state, nxt;
  logic [31:0]        n_q;
  logic [31:0]        din_q;
  logic [31:0]        addr_q;
  logic               we_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        word;
  logic               word_valid;
  logic               accept;
  logic               last;

  // Bytes are only consumed while the stream is being parsed.
  assign accept = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHK);
  assign last   = (32'(idx_q) == (n_q - 32'd1));

  prog_loader_byte_assembler u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .clear      (!accept),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_LEN;
    else       state <= nxt;
  end

  // Write staging is separate from assembly, so a byte arriving during the
  // write cycle already belongs to the next word. Words need 4 bytes, so a
  // new completion can never collide with the pending write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q   <= 1'b0;
      din_q  <= '0;
      addr_q <= ADDR_BASE;
      n_q    <= '0;
      idx_q  <= '0;
    end else begin
      we_q <= (state == ST_DATA) && word_valid;
      if ((state == ST_DATA) && word_valid) begin
        din_q  <= word;
        addr_q <= ADDR_BASE + (32'(idx_q) << 2);
      end
      if ((state == ST_LEN) && word_valid) n_q <= word;
      if (we_q && !last) idx_q <= idx_q + IDX_W'(1);
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sum_q <= '0;
    else if ((state == ST_DATA) && word_valid) sum_q <= sum_q + word;
  end
`endif

  always_comb begin
    nxt      = state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    io_sel   = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      ST_LEN: begin
        if (word_valid) begin
          if (word == 32'd0)                nxt = ST_AFTER_DATA;
          else if (word > 32'(MAX_WORDS))   nxt = ST_NAK;
          else                              nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (we_q && last) nxt = ST_AFTER_DATA;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (word_valid) nxt = (word == sum_q) ? ST_ACK : ST_NAK;
      end
`endif
      ST_ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
        if (tx_ready) nxt = ST_FIN;
      end
      ST_NAK: begin
        tx_valid = 1'b1;
        tx_data  = NAK_BYTE;
        err      = 1'b1;
        if (tx_ready) nxt = ST_HALT;
      end
      ST_FIN: begin
        io_sel = 1'b0;
        done   = 1'b1;
      end
      ST_HALT: begin
        err = 1'b1;
      end
      default: nxt = state;
    endcase
  end

  assign we      = we_q;
  assign en      = we_q;
  assign addr_io = addr_q;
  assign din     = din_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        io_sel, we, en, done, err;
  logic [31:0] addr_io, din;

  prog_loader dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .io_sel(io_sel), .we(we), .en(en), .addr_io(addr_io), .din(din),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  stream[$];
  logic [31:0] tb_sum;
  wr_t         exp_q[$];
  int          exp_nw;
  logic [7:0]  exp_tx;
  logic        exp_done, exp_err;
  int          wr_cnt;
  logic [31:0] act_a[8];
  logic [31:0] act_d[8];
  logic [7:0]  got_tx;
  int          tx_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- stream construction ----------------
  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
  endtask

  task automatic s_start(input logic [31:0] n);
    stream.delete();
    tb_sum = 0;
    push_word(n);
  endtask

  task automatic s_data(input logic [31:0] w);
    push_word(w);
    tb_sum += w;
  endtask

  task automatic s_seal();
`ifdef PROG_LOADER_CHECKSUM_EN
    push_word(tb_sum);
`endif
  endtask

  // ---------------- reference model (stream -> expected effects) ----------------
  function automatic logic [31:0] get_word(input int off);
    logic [31:0] w = 0;
    for (int k = 0; k < 4; k++)
      if (off + k < stream.size()) w[8*k +: 8] = stream[off + k];
    return w;
  endfunction

  task automatic model();
    logic [31:0] n, w, sum;
    wr_t e;
    exp_q.delete();
    exp_nw = 0;
    sum = 0;
    n = get_word(0);
    if (n > 32'd32768) begin
      exp_tx = 8'h55; exp_done = 0; exp_err = 1;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        w = get_word(4 + 4*i);
        e.a = 32'(4*i);
        e.d = w;
        exp_q.push_back(e);
        sum += w;
        exp_nw++;
      end
      exp_tx = 8'hAA; exp_done = 1; exp_err = 0;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (get_word(4 + 4*int'(n)) != sum) begin
        exp_tx = 8'h55; exp_done = 0; exp_err = 1;
      end
`endif
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rstn) begin
      if (we) begin
        wr_t e;
        chk("write_expected", 32'(exp_q.size() != 0), 1);
        chk("en_during_write", en, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("write_addr", addr_io, e.a);
          chk("write_data", din, e.d);
        end
        if (wr_cnt < 8) begin
          act_a[wr_cnt] = addr_io;
          act_d[wr_cnt] = din;
        end
        wr_cnt++;
      end
      if (tx_valid) chk("tx_data_held", tx_data, exp_tx);
      if (tx_valid && tx_ready) begin
        got_tx = tx_data;
        tx_cnt++;
      end
      chk("io_sel_is_not_done", io_sel, !done);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 0;
    rx_valid = 0;
    tx_ready = 0;
    #3;
    chk("rst_io_sel", io_sel, 1);
    chk("rst_we", we, 0);
    chk("rst_en", en, 0);
    chk("rst_addr", addr_io, 32'h0);
    chk("rst_din", din, 32'h0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    exp_q.delete();
    wr_cnt = 0;
    tx_cnt = 0;
    got_tx = 0;
    for (int i = 0; i < 8; i++) begin act_a[i] = 'x; act_d[i] = 'x; end
    @(posedge clk); @(posedge clk); #1;
    rstn = 1;
  endtask

  task automatic send(input int gap, input int nbytes);
    int lim = (nbytes < 0) ? stream.size() : nbytes;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      rx_valid = 1;
      rx_data  = stream[i];
      repeat (gap) begin
        @(posedge clk); #1;
        rx_valid = 0;
      end
    end
    @(posedge clk); #1;
    rx_valid = 0;
  endtask

  task automatic finish_tx(input int hold);
    int t = 0;
    @(negedge clk);
    while (!tx_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("tx_valid_seen", tx_valid, 1);
    if (tx_valid) begin
      repeat (hold) begin
        @(negedge clk);
        chk("tx_valid_hold", tx_valid, 1);
        chk("done_before_handshake", done, 0);
      end
      @(posedge clk); #1;
      tx_ready = 1;
      @(posedge clk); #1;
      tx_ready = 0;
      @(negedge clk);
      chk("tx_count", tx_cnt, 1);
      chk("tx_byte", got_tx, exp_tx);
      chk("done_after", done, exp_done);
      chk("err_after", err, exp_err);
      chk("io_sel_after", io_sel, !exp_done);
      chk("tx_valid_after", tx_valid, 0);
    end
    chk("write_count", wr_cnt, exp_nw);
  endtask

  task automatic run(input int gap, input int hold);
    model();
    send(gap, -1);
    finish_tx(hold);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1; rx_valid = 0; rx_data = 0; tx_ready = 0;
    #2;
    do_reset();

    // Two words, spaced bytes.
    s_start(2); s_data(32'h13); s_data(32'h6F); s_seal();
    run(2, 0);
    chk("t1_w0_addr", act_a[0], 32'h0);
    chk("t1_w0_data", act_d[0], 32'h0000_0013);
    chk("t1_w1_addr", act_a[1], 32'h4);
    chk("t1_w1_data", act_d[1], 32'h0000_006F);
    chk("t1_tx", got_tx, 8'hAA);
    chk("t1_done", done, 1);
    chk("t1_io_sel", io_sel, 0);
    // Bytes after FIN are ignored.
    send(0, 4);
    repeat (3) @(negedge clk);
    chk("t1_fin_ignores_rx", wr_cnt, 2);
    chk("t1_fin_stays_done", done, 1);

    // Empty program.
    do_reset();
    s_start(0); s_seal();
    run(1, 0);
    chk("t2_writes", wr_cnt, 0);
    chk("t2_tx", got_tx, 8'hAA);
    chk("t2_done", done, 1);

    // Oversized count.
    do_reset();
    s_start(32'h0000_8001);
    run(0, 0);
    chk("t3_writes", wr_cnt, 0);
    chk("t3_tx", got_tx, 8'h55);
    chk("t3_err", err, 1);
    chk("t3_done", done, 0);
    chk("t3_io_sel", io_sel, 1);

    // tx_ready held low for 20 cycles.
    do_reset();
    s_start(1); s_data(32'h1234_5678); s_seal();
    run(1, 20);
    chk("t4_done", done, 1);

    // Back-to-back bytes, writes overlap incoming bytes.
    do_reset();
    s_start(3); s_data(32'hA1B2_C3D4); s_data(32'h0000_0001); s_data(32'hFFFF_FFFF); s_seal();
    run(0, 0);
    chk("t5_w2_addr", act_a[2], 32'h8);
    chk("t5_w2_data", act_d[2], 32'hFFFF_FFFF);

    // Reset after 6 bytes, then full stream.
    do_reset();
    s_start(1); s_data(32'hDEAD_BEEF); s_seal();
    model();
    send(0, 6);
    do_reset();
    run(0, 0);
    chk("t6_w0_addr", act_a[0], 32'h0);
    chk("t6_w0_data", act_d[0], 32'hDEAD_BEEF);
    chk("t6_done", done, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    stream = '{8'h02,8'h00,8'h00,8'h00, 8'h01,8'h00,8'h00,8'h00,
               8'h02,8'h00,8'h00,8'h00, 8'h03,8'h00,8'h00,8'h00};
    run(0, 0);
    chk("c1_tx", got_tx, 8'hAA);
    chk("c1_done", done, 1);

    do_reset();
    stream = '{8'h02,8'h00,8'h00,8'h00, 8'h01,8'h00,8'h00,8'h00,
               8'h02,8'h00,8'h00,8'h00, 8'h04,8'h00,8'h00,8'h00};
    run(0, 0);
    chk("c2_tx", got_tx, 8'h55);
    chk("c2_err", err, 1);
    chk("c2_writes", wr_cnt, 2);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
